// File: rtl/demux_pkg.sv
// demux_pkg: shared types and default sizes for the 1-to-N stream demux.
//   mode_e  : SEL routes each word by in_sel; BURST deals burst_len words
//             to each channel in turn.
//   state_e : IDLE (SEL traffic, waiting for a BURST start) / RUN (burst pass).
package demux_pkg;

    typedef enum logic {
        SEL   = 1'b0,
        BURST = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NUM_OUT = 3;
    localparam int DEF_CNT_W   = 10;

endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry output register for a single demux channel.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data this cycle (only asserted when slot_ready)
//   load_data   : word to store
//   down_ready  : downstream ready for this channel
//   slot_ready  : slot can take a word this cycle (empty or draining now)
//   valid, data : channel output; data reads 0 whenever valid is 0
module stream_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              down_ready,
    output logic              slot_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // A draining slot counts as free, so drain and refill in the same cycle
    // keeps a full word per cycle through the channel.
    assign slot_ready = !valid_q || down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (down_ready) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign valid = valid_q;
    assign data  = valid_q ? data_q : '0;

endmodule

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: routes one input stream to NUM_OUT output channels.
//   SEL mode (in IDLE): each word goes to channel in_sel; an out-of-range
//   in_sel is accepted, dropped, and flagged by a one-cycle sel_err pulse.
//   BURST mode (in RUN): after a start pulse, burst_len words go to channel 0,
//   then burst_len to channel 1, ... ; pass_done pulses after the last one.
// Handshake: every port pair uses valid/ready; a word moves on a cycle where
//   both are high, valid never depends on ready, and ready may depend on valid
//   of the same side only through the target slot state.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : input stream
//   in_sel              : SEL-mode target channel
//   mode                : 0 = SEL, 1 = BURST (sampled in IDLE)
//   burst_len, start    : BURST words per channel, pass launch pulse
//   out_data/valid/ready: per-channel outputs, channel k at [k*DATA_W +: DATA_W]
//   busy                : high while a pass is running
//   pass_done, sel_err  : one-cycle status pulses
module stream_demux_1ton
    import demux_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(NUM_OUT)-1:0] in_sel,
    input  logic                       mode,
    input  logic [CNT_W-1:0]           burst_len,
    input  logic                       start,
    output logic [NUM_OUT*DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic                       busy,
    output logic                       pass_done,
    output logic                       sel_err
);

    localparam int SEL_W = $clog2(NUM_OUT);

    state_e             state, state_nx;
    mode_e              mode_c;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0]   len, len_nx;
    logic               pass_done_q, pass_done_nx;
    logic               sel_err_q, sel_err_nx;

    logic [SEL_W-1:0]   target;
    logic               target_ok;
    logic               tgt_ready;
    logic               in_ready_c;
    logic               accept;
    logic [NUM_OUT-1:0] slot_ready;
    logic [NUM_OUT-1:0] load;

    assign mode_c = mode_e'(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            len         <= '0;
            pass_done_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            len         <= len_nx;
            pass_done_q <= pass_done_nx;
            sel_err_q   <= sel_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        cnt_nx       = cnt;
        len_nx       = len;
        pass_done_nx = 1'b0;
        sel_err_nx   = 1'b0;
        target       = ptr;
        target_ok    = 1'b1;
        tgt_ready    = 1'b0;
        in_ready_c   = 1'b0;
        load         = '0;

        if (state == IDLE) begin
            target    = in_sel;
            target_ok = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OUT));
        end

        for (int k = 0; k < NUM_OUT; k++) begin
            if (target == SEL_W'(k)) tgt_ready = slot_ready[k];
        end

        // Out-of-range SEL words are always accepted so they can be dropped.
        if (state == RUN)        in_ready_c = tgt_ready;
        else if (mode_c == SEL)  in_ready_c = target_ok ? tgt_ready : 1'b1;

        // Gated by rst_n so in_ready reads 0 while reset is held.
        accept = rst_n && in_ready_c && in_valid;

        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept && target_ok && (target == SEL_W'(k));
        end

        case (state)
            IDLE: begin
                sel_err_nx = accept && (mode_c == SEL) && !target_ok;
                if ((mode_c == BURST) && start && (burst_len != '0)) begin
                    state_nx = RUN;
                    ptr_nx   = '0;
                    cnt_nx   = '0;
                    len_nx   = burst_len;
                end
            end
            RUN: begin
                if (accept) begin
                    if (cnt == len - CNT_W'(1)) begin
                        cnt_nx = '0;
                        if (ptr == SEL_W'(NUM_OUT - 1)) begin
                            state_nx     = IDLE;
                            ptr_nx       = '0;
                            pass_done_nx = 1'b1;
                        end else begin
                            ptr_nx = ptr + SEL_W'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = rst_n && in_ready_c;
    assign busy      = (state == RUN);
    assign pass_done = pass_done_q;
    assign sel_err   = sel_err_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        stream_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .load_data  (in_data),
            .down_ready (out_ready[k]),
            .slot_ready (slot_ready[k]),
            .valid      (out_valid[k]),
            .data       (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton (DATA_W=16, NUM_OUT=3, CNT_W=10).
// Inputs change 1 time unit after a rising edge; outputs are read on the
// falling edge. A falling-edge monitor pops {channel, word} pairs from the
// expected queue for every output transfer.
module tb_stream_demux_1ton;

    localparam int DW = 16;
    localparam int NO = 3;
    localparam int CW = 10;
    localparam int SW = 2;

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     in_sel;
    logic              mode;
    logic [CW-1:0]     burst_len;
    logic              start;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic              busy;
    logic              pass_done;
    logic              sel_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pd_count = 0;
    bit mon_en   = 1'b0;

    logic [SW+DW-1:0] exp_q[$];

    stream_demux_1ton #(
        .DATA_W  (DW),
        .NUM_OUT (NO),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .mode      (mode),
        .burst_len (burst_len),
        .start     (start),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .pass_done (pass_done),
        .sel_err   (sel_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (pass_done) pd_count++;
            for (int k = 0; k < NO; k++) begin
                logic [SW+DW-1:0] got;
                got = {SW'(k), out_data[k*DW +: DW]};
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q.size() == 0) check("unexpected_word", 0, 1);
                    else                   check("out_word", got, exp_q.pop_front());
                end else if (!out_valid[k]) begin
                    check("idle_data_zero", out_data[k*DW +: DW], 0);
                end
            end
        end
    end

    // Called one unit after a rising edge; leaves the DUT in RUN.
    task automatic start_burst(input int len);
        mode      = 1'b1;
        burst_len = CW'(len);
        start     = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("start_in_ready", in_ready, 0);
        check("start_busy_before", busy, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_busy_after", busy, 1);
        tick();
    endtask

    // Feeds nwords consecutive words base+i; word i belongs to channel i/len.
    // mode and burst_len are disturbed mid-pass and must have no effect.
    // With stall set, channel 1 is held not-ready until three blocked cycles
    // have been seen on the word after its first buffered one.
    task automatic feed_burst(input int len, input int nwords, input int base, input bit stall);
        for (int i = 0; i < nwords; i++) begin
            int wait_cyc;
            wait_cyc = 0;
            in_valid = 1'b1;
            in_data  = DW'(base + i);
            if (i == 1) begin
                burst_len = CW'(7);
                mode      = 1'b0;
            end
            if (stall && i == len + 1) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_ch1_valid", out_valid[1], 1);
                    check("stall_ch1_data", out_data[DW +: DW], DW'(base + len));
                    tick();
                end
                out_ready = 3'b111;
            end
            @(negedge clk);
            while (!in_ready && wait_cyc < 50) begin
                tick();
                wait_cyc++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check("feed_timeout", wait_cyc, 0);
                break;
            end
            exp_q.push_back({SW'(i / len), DW'(base + i)});
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sel    = '0;
        mode      = 1'b0;
        burst_len = '0;
        start     = 1'b0;
        out_ready = '0;

        // reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pass_done", pass_done, 0);
        check("rst_sel_err", sel_err, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 3'b111;
        mon_en    = 1'b1;
        tick();

        // SEL routing to channels 0,1,2
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 16'h1111;
        exp_q.push_back({2'd0, 16'h1111});
        @(negedge clk);
        check("sel_ready0", in_ready, 1);
        tick();
        in_sel  = 2'd1;
        in_data = 16'h2222;
        exp_q.push_back({2'd1, 16'h2222});
        @(negedge clk);
        check("sel_valid0", out_valid, 3'b001);
        check("sel_data0", out_data, 48'h0000_0000_1111);
        check("sel_ready1", in_ready, 1);
        tick();
        in_sel  = 2'd2;
        in_data = 16'h3333;
        exp_q.push_back({2'd2, 16'h3333});
        @(negedge clk);
        check("sel_valid1", out_valid, 3'b010);
        check("sel_data1", out_data, 48'h0000_2222_0000);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("sel_valid2", out_valid, 3'b100);
        check("sel_data2", out_data, 48'h3333_0000_0000);
        tick();
        @(negedge clk);
        check("sel_valid_idle", out_valid, 0);
        check("sel_queue_empty", exp_q.size(), 0);
        tick();

        // SEL with out-of-range channel
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 16'hdead;
        @(negedge clk);
        check("err_in_ready", in_ready, 1);
        check("err_before", sel_err, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("err_pulse", sel_err, 1);
        check("err_no_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check("err_pulse_end", sel_err, 0);
        check("err_no_valid2", out_valid, 0);
        tick();

        // start with burst_len = 0 is ignored
        mode      = 1'b1;
        burst_len = '0;
        start     = 1'b1;
        @(negedge clk);
        check("zlen_in_ready", in_ready, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zlen_busy", busy, 0);
        check("zlen_pass_done", pass_done, 0);
        tick();
        @(negedge clk);
        check("zlen_busy2", busy, 0);
        check("zlen_pd_count", pd_count, 0);
        tick();

        // full BURST pass, burst_len = 4, words 0..11
        pd_count = 0;
        start_burst(4);
        feed_burst(4, 12, 0, 1'b0);
        @(negedge clk);
        check("burst_pass_done", pass_done, 1);
        check("burst_busy_end", busy, 0);
        tick();
        @(negedge clk);
        check("burst_pass_done_end", pass_done, 0);
        check("burst_queue_empty", exp_q.size(), 0);
        check("burst_pd_count", pd_count, 1);
        tick();

        // BURST with channel 1 back-pressured
        pd_count  = 0;
        out_ready = 3'b101;
        start_burst(4);
        feed_burst(4, 12, 32, 1'b1);
        @(negedge clk);
        check("stall_pass_done", pass_done, 1);
        tick();
        @(negedge clk);
        check("stall_queue_empty", exp_q.size(), 0);
        check("stall_pd_count", pd_count, 1);
        tick();

        // reset in the middle of a pass
        pd_count  = 0;
        out_ready = 3'b111;
        start_burst(4);
        feed_burst(4, 6, 200, 1'b0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pass_done", pass_done, 0);
        check("midrst_sel_err", sel_err, 0);
        exp_q.delete();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_out_valid", out_valid, 0);
        tick();
        start_burst(2);
        feed_burst(2, 6, 300, 1'b0);
        @(negedge clk);
        check("restart_pass_done", pass_done, 1);
        tick();
        @(negedge clk);
        check("restart_queue_empty", exp_q.size(), 0);
        check("restart_pd_count", pd_count, 1);
        tick();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
STREAM_DEMUX_1TON -- requirements
Module: stream_demux_1ton

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width.
REQ-002 SHALL have parameter NUM_OUT, default 3, output channel count, legal range 2..8.
REQ-003 SHALL have parameter CNT_W, default 10, burst-length counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  DATA_W  input word.
REQ-007 SHALL have port in_valid  input  1  input word present.
REQ-008 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-009 SHALL have port in_sel  input  $clog2(NUM_OUT)  target channel, SEL mode only.
REQ-010 SHALL have port mode  input  1  0 = SEL, 1 = BURST; sampled only in IDLE.
REQ-011 SHALL have port burst_len  input  CNT_W  words per channel, BURST mode; sampled on start.
REQ-012 SHALL have port start  input  1  single-cycle pulse launching a BURST pass.
REQ-013 SHALL have port out_data  output  NUM_OUT*DATA_W  packed; channel k at [k*DATA_W +: DATA_W].
REQ-014 SHALL have port out_valid  output  NUM_OUT  per-channel valid.
REQ-015 SHALL have port out_ready  input  NUM_OUT  per-channel downstream ready.
REQ-016 SHALL have port busy  output  1  high while in RUN.
REQ-017 SHALL have port pass_done  output  1  one-cycle pulse at BURST pass end.
REQ-018 SHALL have port sel_err  output  1  one-cycle pulse when a SEL-mode word has in_sel >= NUM_OUT.

Function
REQ-019 SHALL implement states IDLE and RUN; SEL mode operates in IDLE, BURST mode in RUN.
REQ-020 Handshake: word transfers iff in_valid && in_ready; out channel k transfers iff out_valid[k] && out_ready[k].
REQ-021 Each channel SHALL hold a one-entry output register; in_ready = target slot empty OR target slot draining this cycle.
REQ-022 Latency SHALL be exactly 1 cycle from input transfer to out_valid of target; throughput 1 word/cycle with out_ready high.
REQ-023 out_data of a channel SHALL read 0 whenever its out_valid is 0; no latched stale data.
REQ-024 SEL mode: target = in_sel each cycle; in_sel >= NUM_OUT -> in_ready = 1, word dropped, sel_err pulses next cycle.
REQ-025 IDLE + mode=1 + start with burst_len != 0 -> RUN, channel pointer 0, word counter 0; in IDLE with mode=1, in_ready = 0.
REQ-026 start with burst_len = 0 SHALL be ignored; start while in RUN SHALL be ignored.
REQ-027 RUN: each accepted word increments counter; at counter = burst_len-1 accept, counter -> 0 and pointer advances.
REQ-028 Accept of last word to channel NUM_OUT-1 SHALL return to IDLE and pulse pass_done the next cycle.
REQ-029 Slot drain and refill on the same channel in the same cycle SHALL be lossless and bubble-free.
REQ-030 mode, burst_len changes during RUN SHALL have no effect until next start.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter 0, pointer 0, all out_valid 0, out_data 0, in_ready 0, busy 0, pass_done 0, sel_err 0.
REQ-032 Reset mid-pass SHALL discard all buffered words; no pass_done issued.

Structure
REQ-033 Package demux_pkg SHALL hold mode_e (SEL, BURST), state_e (IDLE, RUN) and default DATA_W/NUM_OUT/CNT_W constants.
REQ-034 Per-channel register SHALL be sub-module stream_slot, instantiated NUM_OUT times via generate.

Verification
REQ-035 SEL, in_sel 0,1,2, data 0x1111/0x2222/0x3333, out_ready all 1 -> each on its channel one cycle later, others valid 0 and data 0.
REQ-036 SEL, in_sel=3, NUM_OUT=3 -> word dropped, sel_err one pulse, no out_valid.
REQ-037 BURST, burst_len=4, 12 words 0..11 -> ch0 0-3, ch1 4-7, ch2 8-11, pass_done one cycle after word 11, busy low after.
REQ-038 out_ready[1]=0 during BURST ch1 -> in_ready low after one buffered word; release -> no loss, no duplication.
REQ-039 start with burst_len=0 -> stays IDLE, busy 0, no pass_done.
REQ-040 rst_n low after 6 BURST words -> all outputs 0 immediately; new start restarts at ch0.
